// File: rtl/md_sequencer.sv
// Iterative RV32M multiply/divide sequencer: 32-cycle shift-add multiply, radix-2 restoring divide.
// Optional MD_SEQUENCER_FAST_MUL_EN replaces the shift-add multiply with a single-cycle combinational product.
module md_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state, state_nx;
  logic [31:0] hi, lo, opb;
  logic [31:0] hi_nx, lo_nx;
  logic [4:0]  cnt;
  logic [2:0]  op;
  logic        neg;

  logic        a_sgn, b_sgn, neg_in, is_div, div_zero, ovf, special, accept, last;
  logic [31:0] a_mag, b_mag, special_val;
  logic [32:0] sub, sum;

  // Product {hi,lo} (or {remainder,quotient} for divide) of magnitudes -> signed result.
  function automatic logic [31:0] finalize(input logic [2:0] f, input logic n,
                                           input logic [63:0] prod);
    logic [63:0] p;
    logic [31:0] v;
    if (!f[2]) begin
      p = n ? -prod : prod;
      return (f == 3'b000) ? p[31:0] : p[63:32];
    end
    v = f[1] ? prod[63:32] : prod[31:0];
    return n ? -v : v;
  endfunction

  always_comb begin
    a_sgn    = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    b_sgn    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_mag    = (a_sgn && a[31]) ? -a : a;
    b_mag    = (b_sgn && b[31]) ? -b : b;
    // REM follows the dividend sign; every other signed op uses the sign product.
    neg_in   = (funct3[2] && funct3[1]) ? (a_sgn && a[31])
                                        : ((a_sgn && a[31]) ^ (b_sgn && b[31]));
    is_div   = funct3[2];
    div_zero = is_div && (b == '0);
    ovf      = is_div && !funct3[0] && (a == 32'h8000_0000) && (b == '1);
    special  = div_zero || ovf;
    if (div_zero) special_val = funct3[1] ? a : '1;
    else          special_val = funct3[1] ? '0 : 32'h8000_0000;
    accept   = (state == IDLE) && start && !flush;
    last     = (cnt == 5'd31);
  end

  always_comb begin
    sub   = {hi, lo[31]} - {1'b0, opb};
    sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : 33'd0);
    hi_nx = hi;
    lo_nx = lo;
    if (state == DIV) begin
      hi_nx = sub[32] ? {hi[30:0], lo[31]} : sub[31:0];
      lo_nx = {lo[30:0], ~sub[32]};
    end else begin
      hi_nx = sum[32:1];
      lo_nx = {sum[0], lo[31:1]};
    end
  end

`ifdef MD_SEQUENCER_FAST_MUL_EN
  logic [63:0] fast_prod;
  assign fast_prod = {32'd0, a_mag} * {32'd0, b_mag};
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) begin
        if (special)     state_nx = DONE;
        else if (is_div) state_nx = DIV;
        else begin
`ifdef MD_SEQUENCER_FAST_MUL_EN
          state_nx = DONE;
`else
          state_nx = MUL;
`endif
        end
      end
      MUL, DIV: begin
        if (flush)     state_nx = IDLE;
        else if (last) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi     <= '0;
      lo     <= '0;
      opb    <= '0;
      cnt    <= '0;
      op     <= '0;
      neg    <= 1'b0;
      result <= '0;
    end else if (accept) begin
      op  <= funct3;
      neg <= neg_in;
      cnt <= '0;
      hi  <= '0;
      lo  <= is_div ? a_mag : b_mag;
      opb <= is_div ? b_mag : a_mag;
      if (special) result <= special_val;
`ifdef MD_SEQUENCER_FAST_MUL_EN
      else if (!is_div) result <= finalize(funct3, neg_in, fast_prod);
`endif
    end else if ((state == MUL || state == DIV) && !flush) begin
      hi  <= hi_nx;
      lo  <= lo_nx;
      cnt <= cnt + 5'd1;
      if (last) result <= finalize(op, neg, {hi_nx, lo_nx});
    end
  end

  assign stall = rst_n && (accept || state == MUL || state == DIV);
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

endmodule

// File: doc/md_sequencer.md
MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 Parameters SHALL be none; operand and result width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-004 start  input  1  M-extension instruction present in Execute (decoder is_M, pipelined).
REQ-005 funct3  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 a  input  32  rs1 operand (multiplicand / dividend).
REQ-007 b  input  32  rs2 operand (multiplier / divisor).
REQ-008 flush  input  1  Execute-stage flush; aborts any operation in progress.
REQ-009 stall  output  1  freezes F/D/E stages while an operation is in progress.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 done  output  1  one-cycle pulse; result valid.
REQ-012 result  output  32  operation result; held stable until the next accepted start.

Function
REQ-013 FSM states SHALL be IDLE, MUL, DIV and DONE.
REQ-014 start SHALL be accepted only in IDLE with flush low; operands and funct3 are captured on the accepting edge.
REQ-015 start in MUL, DIV or DONE SHALL be ignored.
REQ-016 stall SHALL be combinational: high when (IDLE and start and not flush), or in MUL or DIV; low in DONE.
REQ-017 Iterative ops SHALL run 32 iteration cycles after acceptance at cycle T, then DONE at T+33 (done=1); stall is high for cycles T..T+32 (33 cycles).
REQ-018 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-019 Signed ops SHALL be performed on magnitudes, with a conditional final negation:
- MULH: both operands signed.
- MULHSU: a signed, b unsigned.
- DIV: quotient negative iff the operand signs differ.
- REM: remainder takes the dividend's sign.
REQ-020 MUL SHALL return product bits [31:0]; MULH/MULHSU/MULHU SHALL return bits [63:32] of the 64-bit product.
REQ-021 Division SHALL be radix-2 restoring, one quotient bit per cycle, using a 33-bit partial-remainder subtract.
REQ-022 Divide by zero SHALL skip iteration and go straight to DONE at T+1:
- DIV/DIVU: result 0xFFFFFFFF.
- REM/REMU: result a.
REQ-023 Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF) SHALL go straight to DONE at T+1: DIV returns 0x80000000, REM returns 0.
REQ-024 flush SHALL have priority over start and over iteration; the FSM returns to IDLE next cycle with no done pulse, and result keeps its previous value.
REQ-025 done SHALL never assert without a prior accepted start.

Reset
REQ-026 rst_n low at a clock edge SHALL force IDLE, with done=0, busy=0 and result=0, and clear the iteration counter and internal registers.
REQ-027 Reset mid-operation SHALL abandon the operation with no done pulse.
REQ-028 While rst_n is low, stall SHALL be 0 regardless of start.

Configuration
REQ-029 Macro MD_SEQUENCER_FAST_MUL_EN selects the multiply implementation:
- Defined: MUL* ops compute a combinational 64-bit product, go IDLE to DONE at T+1, and stall for cycle T only.
- Undefined: MUL* ops use a 32-cycle shift-add in state MUL, with the same timing as divide.
- Division behaviour SHALL be identical in both builds.

Verification
REQ-030 Reset, then start, DIVU, a=100, b=7 -> stall high 33 cycles, done at T+33, result=14; repeat with REMU -> result=2.
REQ-031 DIV a=0xFFFFFF9C (-100), b=7 -> result 0xFFFFFFF2 (-14); REM with the same operands -> result 0xFFFFFFFE (-2).
REQ-032 DIVU a=5, b=0 -> done at T+1, result 0xFFFFFFFF; REM a=0x80000000, b=0xFFFFFFFF -> done at T+1, result 0.
REQ-033 MULH a=0xFFFFFFFF, b=0xFFFFFFFF -> result 0; MULHU with the same operands -> result 0xFFFFFFFE; MUL a=3, b=5 -> result 15. Latency is 1 cycle with MD_SEQUENCER_FAST_MUL_EN defined and 33 cycles without it.
REQ-034 Start DIVU, then assert flush at T+10 -> IDLE next cycle, no done, result unchanged; a new start one cycle later completes normally.
REQ-035 Start DIV, deassert rst_n at T+5 for one cycle -> IDLE, result=0, no done; start held high during the busy state -> no second acceptance.
